n101_gnrl_ram_arbt: RTL and testbench

Two-requester arbiter and sequencer in front of one `n101_gnrl_ram` instance, e.g. an ITCM shared between instruction fetch and the LSU. It grants one command per cycle to the single-port RAM and tracks the 1-cycle synchronous read latency. It routes each response back to its owner and holds it in a one-entry buffer when the owner is not ready. All state is local; the RAM itself is untouched.

---
 rtl/n101_gnrl_ram_arbt_pkg.sv | 15 +
 rtl/n101_gnrl_ram_arbt_rbuf.sv | 50 +++++
 rtl/n101_gnrl_ram_arbt.sv | 194 +++++++++++++++++++
 tb/tb_n101_gnrl_ram_arbt.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/n101_gnrl_ram_arbt_pkg.sv
// rtl/n101_gnrl_ram_arbt_pkg.sv - shared types for the two-requester RAM arbiter
// Purpose: response FSM state encoding and requester-index constants.
// Ports: none (package).
package n101_gnrl_ram_arbt_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,   // nothing outstanding
      ST_INFLT = 2'b01,   // RAM read data valid this cycle
      ST_HOLD  = 2'b10    // response parked in the holding buffer
   } arbt_state_e;

   localparam logic REQ_0 = 1'b0;
   localparam logic REQ_1 = 1'b1;

endpackage

// File: rtl/n101_gnrl_ram_arbt_rbuf.sv
// rtl/n101_gnrl_ram_arbt_rbuf.sv - one-entry response holding register
// Purpose: parks a response whose owner was not ready in the RAM data cycle.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   load_i / clr_i          capture a response / release the entry
//   own_i, read_i, rdata_i  owner, type (1 = read) and raw RAM data to capture
//   vld_o, own_o, read_o, rdata_o  stored entry
module n101_gnrl_ram_arbt_rbuf #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_i,
   input  logic          clr_i,
   input  logic          own_i,
   input  logic          read_i,
   input  logic [DW-1:0] rdata_i,
   output logic          vld_o,
   output logic          own_o,
   output logic          read_o,
   output logic [DW-1:0] rdata_o
);

   logic          vld_q;
   logic          own_q;
   logic          read_q;
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q   <= 1'b0;
         own_q   <= 1'b0;
         read_q  <= 1'b0;
         rdata_q <= '0;
      end else if (load_i) begin
         vld_q   <= 1'b1;
         own_q   <= own_i;
         read_q  <= read_i;
         rdata_q <= rdata_i;
      end else if (clr_i) begin
         vld_q   <= 1'b0;
      end
   end

   assign vld_o   = vld_q;
   assign own_o   = own_q;
   assign read_o  = read_q;
   assign rdata_o = rdata_q;

endmodule

// File: rtl/n101_gnrl_ram_arbt.sv
// rtl/n101_gnrl_ram_arbt.sv - two-requester arbiter/sequencer for one single-port RAM
// Purpose: grants one command per cycle to the RAM, tracks the 1-cycle read
//   latency and returns each response to its owner, holding it when stalled.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   rN_cmd_valid/ready/read/addr/wdata/wmask   command channel of requester N
//   rN_rsp_valid/ready/rdata        response channel of requester N
//   ram_cs/we/addr/din/wem, ram_dout  RAM port (dout valid the cycle after cs)
// Config: N101_RAM_ARBT_RR_EN selects round-robin; otherwise r0 has fixed priority.
module n101_gnrl_ram_arbt
   import n101_gnrl_ram_arbt_pkg::*;
#(
   parameter int DW = 32,
   parameter int MW = DW/8,
   parameter int AW = 15
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          r0_cmd_valid,
   output logic          r0_cmd_ready,
   input  logic          r0_cmd_read,
   input  logic [AW-1:0] r0_cmd_addr,
   input  logic [DW-1:0] r0_cmd_wdata,
   input  logic [MW-1:0] r0_cmd_wmask,
   output logic          r0_rsp_valid,
   input  logic          r0_rsp_ready,
   output logic [DW-1:0] r0_rsp_rdata,
   input  logic          r1_cmd_valid,
   output logic          r1_cmd_ready,
   input  logic          r1_cmd_read,
   input  logic [AW-1:0] r1_cmd_addr,
   input  logic [DW-1:0] r1_cmd_wdata,
   input  logic [MW-1:0] r1_cmd_wmask,
   output logic          r1_rsp_valid,
   input  logic          r1_rsp_ready,
   output logic [DW-1:0] r1_rsp_rdata,
   output logic          ram_cs,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   output logic [MW-1:0] ram_wem,
   input  logic [DW-1:0] ram_dout
);

   arbt_state_e   state_q, state_d;
   logic          own_q, own_d;
   logic          rd_q, rd_d;        // type of the response currently in the RAM data cycle
   logic          prio;
   logic          own_rdy;
   logic          allow;
   logic          pick1;
   logic          gnt0, gnt1, gnt;
   logic          gidx;
   logic          g_read;
   logic          buf_load, buf_clr;
   logic          buf_vld, buf_own, buf_read;
   logic [DW-1:0] buf_rdata;
   logic          rsp_any;
   logic          rsp_own;
   logic [DW-1:0] rsp_data;

   assign own_rdy = own_q ? r1_rsp_ready : r0_rsp_ready;

   // New grants only when nothing is outstanding, or when the in-flight
   // response is consumed this very cycle. rst_n gates grants so cmd_ready
   // stays low while reset is held.
   assign allow = rst_n & ((state_q == ST_EMPTY) | ((state_q == ST_INFLT) & own_rdy));

   assign pick1 = r1_cmd_valid & (~r0_cmd_valid | (prio == REQ_1));
   assign gnt1  = allow & pick1;
   assign gnt0  = allow & r0_cmd_valid & ~pick1;
   assign gnt   = gnt0 | gnt1;
   assign gidx  = gnt1 ? REQ_1 : REQ_0;

   assign r0_cmd_ready = gnt0;
   assign r1_cmd_ready = gnt1;

   assign g_read   = gidx ? r1_cmd_read  : r0_cmd_read;
   assign ram_cs   = gnt;
   assign ram_we   = gnt & ~g_read;
   assign ram_addr = gidx ? r1_cmd_addr  : r0_cmd_addr;
   assign ram_din  = gidx ? r1_cmd_wdata : r0_cmd_wdata;
   assign ram_wem  = gnt ? (gidx ? r1_cmd_wmask : r0_cmd_wmask) : '0;

`ifdef N101_RAM_ARBT_RR_EN
   logic prio_q, prio_d;

   // After a grant to N the other requester wins the next tie.
   always_comb begin
      prio_d = prio_q;
      if (gnt) begin
         prio_d = ~gidx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_q <= REQ_0;
      end else begin
         prio_q <= prio_d;
      end
   end

   assign prio = prio_q;
`else
   assign prio = REQ_0;
`endif

   always_comb begin
      state_d  = state_q;
      own_d    = own_q;
      rd_d     = rd_q;
      buf_load = 1'b0;
      buf_clr  = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (gnt) begin
               state_d = ST_INFLT;
               own_d   = gidx;
               rd_d    = g_read;
            end
         end
         ST_INFLT: begin
            if (own_rdy) begin
               if (gnt) begin
                  own_d = gidx;
                  rd_d  = g_read;
               end else begin
                  state_d = ST_EMPTY;
               end
            end else begin
               // RAM data is only valid this cycle; park it.
               state_d  = ST_HOLD;
               buf_load = 1'b1;
            end
         end
         ST_HOLD: begin
            if (own_rdy) begin
               state_d = ST_EMPTY;
               buf_clr = 1'b1;
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         own_q   <= REQ_0;
         rd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         own_q   <= own_d;
         rd_q    <= rd_d;
      end
   end

   n101_gnrl_ram_arbt_rbuf #(.DW(DW)) u_rbuf (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (buf_load),
      .clr_i   (buf_clr),
      .own_i   (own_q),
      .read_i  (rd_q),
      .rdata_i (ram_dout),
      .vld_o   (buf_vld),
      .own_o   (buf_own),
      .read_o  (buf_read),
      .rdata_o (buf_rdata)
   );

   always_comb begin
      rsp_any  = 1'b0;
      rsp_own  = own_q;
      rsp_data = '0;
      if (state_q == ST_INFLT) begin
         rsp_any  = 1'b1;
         rsp_data = rd_q ? ram_dout : '0;
      end else if (state_q == ST_HOLD) begin
         rsp_any  = buf_vld;
         rsp_own  = buf_own;
         rsp_data = buf_read ? buf_rdata : '0;
      end
   end

   assign r0_rsp_valid = rsp_any & (rsp_own == REQ_0);
   assign r1_rsp_valid = rsp_any & (rsp_own == REQ_1);
   assign r0_rsp_rdata = r0_rsp_valid ? rsp_data : '0;
   assign r1_rsp_rdata = r1_rsp_valid ? rsp_data : '0;

endmodule

// File: tb/tb_n101_gnrl_ram_arbt.sv
// tb/tb_n101_gnrl_ram_arbt.sv - self-checking bench for n101_gnrl_ram_arbt
module tb_n101_gnrl_ram_arbt;

   localparam int DW = 32;
   localparam int MW = 4;
   localparam int AW = 15;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          r0_cmd_valid, r0_cmd_ready, r0_cmd_read;
   logic [AW-1:0] r0_cmd_addr;
   logic [DW-1:0] r0_cmd_wdata;
   logic [MW-1:0] r0_cmd_wmask;
   logic          r0_rsp_valid, r0_rsp_ready;
   logic [DW-1:0] r0_rsp_rdata;
   logic          r1_cmd_valid, r1_cmd_ready, r1_cmd_read;
   logic [AW-1:0] r1_cmd_addr;
   logic [DW-1:0] r1_cmd_wdata;
   logic [MW-1:0] r1_cmd_wmask;
   logic          r1_rsp_valid, r1_rsp_ready;
   logic [DW-1:0] r1_rsp_rdata;
   logic          ram_cs, ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic [MW-1:0] ram_wem;
   logic [DW-1:0] ram_dout = '0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   n101_gnrl_ram_arbt #(.DW(DW), .MW(MW), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .r0_cmd_valid(r0_cmd_valid), .r0_cmd_ready(r0_cmd_ready), .r0_cmd_read(r0_cmd_read),
      .r0_cmd_addr(r0_cmd_addr), .r0_cmd_wdata(r0_cmd_wdata), .r0_cmd_wmask(r0_cmd_wmask),
      .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready), .r0_rsp_rdata(r0_rsp_rdata),
      .r1_cmd_valid(r1_cmd_valid), .r1_cmd_ready(r1_cmd_ready), .r1_cmd_read(r1_cmd_read),
      .r1_cmd_addr(r1_cmd_addr), .r1_cmd_wdata(r1_cmd_wdata), .r1_cmd_wmask(r1_cmd_wmask),
      .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready), .r1_rsp_rdata(r1_rsp_rdata),
      .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
      .ram_wem(ram_wem), .ram_dout(ram_dout)
   );

   function automatic logic [31:0] init_pat(input int a);
      logic [7:0] b;
      b = 8'(a);
      return {b, 8'h5A, ~b, 8'hC3};
   endfunction

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b expected=%b at %0t", nm, act, exp, $time);
      end
   endtask

   // Single-port RAM with 1-cycle read latency; dout is garbage when not selected.
   logic [31:0] mem [0:255];
   initial for (int i = 0; i < 256; i++) mem[i] = init_pat(i);

   always @(posedge clk) begin
      logic [31:0] t;
      if (ram_cs) begin
         if (ram_we) begin
            t = mem[ram_addr[7:0]];
            for (int b = 0; b < MW; b++) if (ram_wem[b]) t[b*8 +: 8] = ram_din[b*8 +: 8];
            mem[ram_addr[7:0]] <= t;
         end else begin
            ram_dout <= mem[ram_addr[7:0]];
         end
      end else begin
         ram_dout <= $urandom;
      end
   end

   // Reference model: at most one outstanding response (owner, data, whether
   // it was issued last cycle). Grants are legal when nothing is outstanding,
   // or the outstanding one is fresh and is being accepted now.
   logic [31:0] ref_mem [0:255];
   initial for (int i = 0; i < 256; i++) ref_mem[i] = init_pat(i);
   bit          m_v = 0, m_own = 0, m_fresh = 0, m_prio = 0;
   logic [31:0] m_data = '0;

   always @(negedge clk) begin
      bit          own_rdy, allow, win, any, w_read;
      logic [AW-1:0] w_addr;
      logic [31:0] w_data, t;
      logic [3:0]  w_mask;
      #2;
      if (!rst_n) begin
         m_v = 0; m_own = 0; m_fresh = 0; m_prio = 0;
         chk1("m_rst_r0_cmd_ready", r0_cmd_ready, 1'b0);
         chk1("m_rst_r1_cmd_ready", r1_cmd_ready, 1'b0);
         chk1("m_rst_ram_cs", ram_cs, 1'b0);
         chk1("m_rst_r0_rsp_valid", r0_rsp_valid, 1'b0);
         chk1("m_rst_r1_rsp_valid", r1_rsp_valid, 1'b0);
         chk32("m_rst_r0_rdata", r0_rsp_rdata, 32'h0);
         chk32("m_rst_r1_rdata", r1_rsp_rdata, 32'h0);
      end else begin
         own_rdy = m_own ? r1_rsp_ready : r0_rsp_ready;
         allow   = !m_v || (m_fresh && own_rdy);
         win     = (r0_cmd_valid && r1_cmd_valid) ? m_prio : r1_cmd_valid;
         any     = allow && (r0_cmd_valid || r1_cmd_valid);
         w_read  = win ? r1_cmd_read  : r0_cmd_read;
         w_addr  = win ? r1_cmd_addr  : r0_cmd_addr;
         w_data  = win ? r1_cmd_wdata : r0_cmd_wdata;
         w_mask  = win ? r1_cmd_wmask : r0_cmd_wmask;
         chk1("m_r0_cmd_ready", r0_cmd_ready, any && !win);
         chk1("m_r1_cmd_ready", r1_cmd_ready, any && win);
         chk1("m_ram_cs", ram_cs, any);
         chk1("m_ram_we", ram_we, any && !w_read);
         if (any) begin
            chk32("m_ram_addr", 32'(ram_addr), 32'(w_addr));
            chk32("m_ram_wem", 32'(ram_wem), 32'(w_mask));
            if (!w_read) chk32("m_ram_din", ram_din, w_data);
         end else begin
            chk32("m_ram_wem_idle", 32'(ram_wem), 32'h0);
         end
         chk1("m_r0_rsp_valid", r0_rsp_valid, m_v && !m_own);
         chk1("m_r1_rsp_valid", r1_rsp_valid, m_v && m_own);
         chk32("m_r0_rsp_rdata", r0_rsp_rdata, (m_v && !m_own) ? m_data : 32'h0);
         chk32("m_r1_rsp_rdata", r1_rsp_rdata, (m_v && m_own) ? m_data : 32'h0);
         if (any) begin
            if (w_read) begin
               m_data = ref_mem[w_addr[7:0]];
            end else begin
               m_data = '0;
               t = ref_mem[w_addr[7:0]];
               for (int b = 0; b < 4; b++) if (w_mask[b]) t[b*8 +: 8] = w_data[b*8 +: 8];
               ref_mem[w_addr[7:0]] = t;
            end
            m_v = 1; m_fresh = 1; m_own = win;
`ifdef N101_RAM_ARBT_RR_EN
            m_prio = !win;
`endif
         end else if (m_v && own_rdy) begin
            m_v = 0;
         end else if (m_v) begin
            m_fresh = 0;
         end
      end
   end

   task automatic idle();
      r0_cmd_valid = 0; r0_cmd_read = 1; r0_cmd_addr = '0; r0_cmd_wdata = '0; r0_cmd_wmask = '0;
      r1_cmd_valid = 0; r1_cmd_read = 1; r1_cmd_addr = '0; r1_cmd_wdata = '0; r1_cmd_wmask = '0;
      r0_rsp_ready = 1; r1_rsp_ready = 1;
   endtask

   typedef struct {
      bit v0, v1;
      bit e0, e1;
   } vec_t;
   vec_t tbl [7];

   initial begin
      // contention table: r0/r1 valid -> expected r0/r1 grant
      tbl[0] = '{1, 1, 1, 0};
`ifdef N101_RAM_ARBT_RR_EN
      tbl[1] = '{1, 1, 0, 1};
      tbl[2] = '{1, 1, 1, 0};
      tbl[3] = '{1, 1, 0, 1};
`else
      tbl[1] = '{1, 1, 1, 0};
      tbl[2] = '{1, 1, 1, 0};
      tbl[3] = '{1, 1, 1, 0};
`endif
      tbl[4] = '{0, 1, 0, 1};
      tbl[5] = '{1, 1, 1, 0};
      tbl[6] = '{0, 0, 0, 0};

      idle();
      rst_n = 0;

      // reset held with both requesters valid
      r0_cmd_valid = 1; r1_cmd_valid = 1;
      repeat (3) @(negedge clk);
      #3;
      chk1("rst_r0_cmd_ready", r0_cmd_ready, 1'b0);
      chk1("rst_r1_cmd_ready", r1_cmd_ready, 1'b0);
      chk1("rst_ram_cs", ram_cs, 1'b0);
      chk1("rst_r0_rsp_valid", r0_rsp_valid, 1'b0);
      chk1("rst_r1_rsp_valid", r1_rsp_valid, 1'b0);
      @(negedge clk);
      rst_n = 1;
      #3;
      chk1("rel_r0_first", r0_cmd_ready, 1'b1);
      chk1("rel_r1_waits", r1_cmd_ready, 1'b0);
      @(negedge clk);
      idle();

      // contention table from a fresh reset
      @(negedge clk); rst_n = 0;
      @(negedge clk); rst_n = 1;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         r0_cmd_valid = tbl[i].v0; r0_cmd_addr = AW'(i);
         r1_cmd_valid = tbl[i].v1; r1_cmd_addr = AW'(i + 8);
         #3;
         chk1($sformatf("tbl%0d_r0_grant", i), r0_cmd_ready, tbl[i].e0);
         chk1($sformatf("tbl%0d_r1_grant", i), r1_cmd_ready, tbl[i].e1);
         chk1($sformatf("tbl%0d_ram_cs", i), ram_cs, tbl[i].e0 | tbl[i].e1);
      end
      @(negedge clk); idle();

      // back-to-back reads 0..7
      for (int i = 0; i <= 8; i++) begin
         @(negedge clk);
         r0_cmd_valid = (i < 8); r0_cmd_read = 1; r0_cmd_addr = AW'(i);
         #3;
         if (i < 8) chk1($sformatf("b2b_grant%0d", i), r0_cmd_ready, 1'b1);
         if (i > 0) begin
            chk1($sformatf("b2b_rsp_valid%0d", i - 1), r0_rsp_valid, 1'b1);
            chk32($sformatf("b2b_rsp_rdata%0d", i - 1), r0_rsp_rdata, init_pat(i - 1));
         end
      end
      @(negedge clk); idle();

      // read-after-write on r0
      @(negedge clk);
      r0_cmd_valid = 1; r0_cmd_read = 0; r0_cmd_addr = AW'(16'h10);
      r0_cmd_wdata = 32'hDEADBEEF; r0_cmd_wmask = 4'hF;
      #3 chk1("raw_wr_we", ram_we, 1'b1);
      @(negedge clk);
      r0_cmd_read = 1; r0_cmd_wmask = 4'h0;
      #3;
      chk1("raw_wr_rsp_valid", r0_rsp_valid, 1'b1);
      chk32("raw_wr_rsp_rdata", r0_rsp_rdata, 32'h0);
      chk1("raw_rd_granted", r0_cmd_ready, 1'b1);
      @(negedge clk);
      idle();
      #3;
      chk1("raw_rd_rsp_valid", r0_rsp_valid, 1'b1);
      chk32("raw_rd_rsp_rdata", r0_rsp_rdata, 32'hDEADBEEF);
      @(negedge clk); idle();

      // backpressure on r1
      @(negedge clk);
      r1_cmd_valid = 1; r1_cmd_read = 0; r1_cmd_addr = AW'(5); r1_cmd_wdata = 32'h1234; r1_cmd_wmask = 4'hF;
      @(negedge clk);
      r1_cmd_read = 1; r1_cmd_wmask = 4'h0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         r0_cmd_valid = 1; r1_cmd_valid = 1; r1_rsp_ready = 0;
         #3;
         chk1($sformatf("bp_no_cs%0d", i), ram_cs, 1'b0);
         chk1($sformatf("bp_rsp_valid%0d", i), r1_rsp_valid, 1'b1);
         chk32($sformatf("bp_rsp_rdata%0d", i), r1_rsp_rdata, 32'h1234);
      end
      @(negedge clk);
      r0_cmd_valid = 0; r1_cmd_valid = 0; r1_rsp_ready = 1;
      #3;
      chk1("bp_hs_valid", r1_rsp_valid, 1'b1);
      chk32("bp_hs_rdata", r1_rsp_rdata, 32'h1234);
      @(negedge clk);
      r0_cmd_valid = 1;
      #3;
      chk1("bp_empty_no_rsp", r1_rsp_valid, 1'b0);
      chk1("bp_empty_grant", r0_cmd_ready, 1'b1);
      @(negedge clk); idle();
      @(negedge clk);

      // reset during the response cycle
      @(negedge clk);
      r0_cmd_valid = 1; r0_cmd_addr = AW'(3);
      @(negedge clk);
      idle(); rst_n = 0;
      #3;
      chk1("mid_rst_rsp_drop", r0_rsp_valid, 1'b0);
      chk32("mid_rst_rdata", r0_rsp_rdata, 32'h0);
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #3 chk1($sformatf("mid_rst_no_rsp%0d", i), r0_rsp_valid, 1'b0);
      end

      // randomized traffic against the reference model
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         rst_n        = ($urandom_range(0, 499) != 0);
         r0_cmd_valid = ($urandom_range(0, 9) < 6);
         r0_cmd_read  = $urandom_range(0, 1);
         r0_cmd_addr  = AW'($urandom_range(0, 15));
         r0_cmd_wdata = $urandom;
         r0_cmd_wmask = 4'($urandom_range(0, 15));
         r1_cmd_valid = ($urandom_range(0, 9) < 6);
         r1_cmd_read  = $urandom_range(0, 1);
         r1_cmd_addr  = AW'($urandom_range(0, 15));
         r1_cmd_wdata = $urandom;
         r1_cmd_wmask = 4'($urandom_range(0, 15));
         r0_rsp_ready = ($urandom_range(0, 3) != 0);
         r1_rsp_ready = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      idle(); rst_n = 1;
      #4;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
